// File: rtl/mac_filter.sv
// rtl/mac_filter.sv - destination MAC filter and header stripper for the RMII dibit receive path
// Optional macro MAC_FILTER_BCAST_EN also accepts broadcast destination frames.
module mac_filter #(
    parameter logic [47:0] MY_MAC = 48'h692C083075FD
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       axiiv,
    input  logic [1:0] axiid,
    output logic       axiov,
    output logic [1:0] axiod
);
    typedef enum logic [2:0] {SYNC, IDLE, DST, HDR, PASS, DROP} state_t;

    state_t      state;
    state_t      state_nxt;
    logic [5:0]  cnt;
    logic        m_my;
    logic [47:0] mac_shift;
    logic        my_hit;
    logic        accept;
    logic        fwd;
`ifdef MAC_FILTER_BCAST_EN
    logic        m_bc;
    logic        bc_hit;

    assign bc_hit = (axiid == 2'b11);
`endif

    // cnt is 0 in IDLE, so the same shifter yields dibit 0 there and dibit k in DST
    assign mac_shift = MY_MAC << {cnt[4:0], 1'b0};
    assign my_hit    = (axiid == mac_shift[47:46]);
    assign fwd       = (state == PASS) && axiiv;

    always_comb begin
        state_nxt = state;
        accept    = m_my && my_hit;
`ifdef MAC_FILTER_BCAST_EN
        accept    = accept || (m_bc && bc_hit);
`endif
        case (state)
            SYNC: if (!axiiv) state_nxt = IDLE;
            IDLE: if (axiiv) state_nxt = DST;
            DST: begin
                if (!axiiv)
                    state_nxt = IDLE;
                else if (cnt == 6'd23)
                    state_nxt = accept ? HDR : DROP;
            end
            HDR: begin
                if (!axiiv)
                    state_nxt = IDLE;
                else if (cnt == 6'd55)
                    state_nxt = PASS;
            end
            PASS, DROP: if (!axiiv) state_nxt = IDLE;
            default: state_nxt = SYNC;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state <= SYNC;
            cnt   <= 6'd0;
            m_my  <= 1'b1;
`ifdef MAC_FILTER_BCAST_EN
            m_bc  <= 1'b1;
`endif
            axiov <= 1'b0;
            axiod <= 2'b00;
        end else begin
            state <= state_nxt;
            axiov <= fwd;
            axiod <= fwd ? axiid : 2'b00;
            if (state == IDLE && axiiv) begin
                cnt  <= 6'd1;
                m_my <= my_hit;
`ifdef MAC_FILTER_BCAST_EN
                m_bc <= bc_hit;
`endif
            end else if (state == DST && axiiv) begin
                cnt  <= cnt + 6'd1;
                m_my <= m_my && my_hit;
`ifdef MAC_FILTER_BCAST_EN
                m_bc <= m_bc && bc_hit;
`endif
            end else if ((state == HDR || state == PASS || state == DROP) && axiiv) begin
                if (cnt != 6'd56)
                    cnt <= cnt + 6'd1;
            end else if (!axiiv) begin
                // gap between frames: rearm counter and match flags for the next dibit 0
                cnt  <= 6'd0;
                m_my <= 1'b1;
`ifdef MAC_FILTER_BCAST_EN
                m_bc <= 1'b1;
`endif
            end
        end
    end
endmodule

// File: tb/tb_mac_filter.sv
// tb/tb_mac_filter.sv - scoreboard testbench for mac_filter
module tb_mac_filter;
    localparam logic [47:0] MY_MAC = 48'h692C083075FD;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       axiiv = 1'b0;
    logic [1:0] axiid = 2'b00;
    logic       axiov;
    logic [1:0] axiod;

    int         cyc = 0;
    int         frame_start = 0;
    int         n_cmp = 0;
    int         n_err = 0;
    logic       prev_v = 1'b0;
    logic       mon_en = 1'b0;
    logic       bc_en;
    logic [1:0] sb [$];
    logic [7:0] fbuf [0:127];

    mac_filter #(.MY_MAC(MY_MAC)) dut (
        .clk   (clk),
        .rst   (rst),
        .axiiv (axiiv),
        .axiid (axiid),
        .axiov (axiov),
        .axiod (axiod)
    );

    always #10 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", tag, got, exp, cyc);
        end
    endtask

    always @(negedge clk) begin
        if (mon_en) begin
            if (axiov === 1'b1) begin
                if (!prev_v)
                    check_eq("latency", cyc - frame_start, 57);
                if (sb.size() == 0)
                    check_eq("spurious_v", {31'd0, axiov}, 0);
                else
                    check_eq("data", {30'd0, axiod}, {30'd0, sb.pop_front()});
            end else begin
                check_eq("idle_v", {31'd0, axiov}, 0);
                check_eq("idle_d", {30'd0, axiod}, 0);
            end
            prev_v = (axiov === 1'b1);
        end
    end

    task automatic set_hdr(input logic [47:0] dst);
        logic [47:0] t;
        for (int i = 0; i < 6; i++) begin
            t = dst << (8 * i);
            fbuf[i] = t[47:40];
        end
        for (int i = 6; i < 12; i++) fbuf[i] = 8'($urandom);
        fbuf[12] = 8'h08;
        fbuf[13] = 8'h00;
    endtask

    task automatic send_frame(input int ndib, input int rst_at, input int gap);
        logic        acc;
        logic        bc;
        logic [7:0]  b;
        logic [47:0] t;
        acc = 1'b1;
        bc  = 1'b1;
        for (int i = 0; i < 6; i++) begin
            t = MY_MAC << (8 * i);
            if (fbuf[i] != t[47:40]) acc = 1'b0;
            if (fbuf[i] != 8'hFF) bc = 1'b0;
        end
        acc = acc || (bc && bc_en);
        for (int k = 0; k < ndib; k++) begin
            @(posedge clk); #1;
            b = fbuf[k / 4] << (2 * (k % 4));
            axiiv = 1'b1;
            axiid = b[7:6];
            rst   = (k == rst_at);
            if (k == 0) frame_start = cyc;
            if (acc && k >= 56 && (rst_at < 0 || k < rst_at))
                sb.push_back(b[7:6]);
        end
        @(posedge clk); #1;
        axiiv = 1'b0;
        axiid = 2'b00;
        rst   = 1'b0;
        @(negedge clk); #1;
        check_eq("drain", sb.size(), 0);
        for (int g = 1; g < gap; g++) @(posedge clk);
    endtask

    initial begin
`ifdef MAC_FILTER_BCAST_EN
        bc_en = 1'b1;
`else
        bc_en = 1'b0;
`endif
        rst = 1'b1;
        @(posedge clk);
        mon_en = 1'b1;
        for (int i = 0; i < 2; i++) begin
            #1 {axiiv, axiid} = 3'($urandom);
            @(negedge clk);
            check_eq("rst_v", {31'd0, axiov}, 0);
            check_eq("rst_d", {30'd0, axiod}, 0);
            @(posedge clk);
        end
        #1;
        rst   = 1'b0;
        axiiv = 1'b0;
        axiid = 2'b00;
        repeat (2) @(posedge clk);

        // unicast hit, payload 12 34
        set_hdr(MY_MAC);
        fbuf[14] = 8'h12; fbuf[15] = 8'h34;
        send_frame(64, -1, 1);

        // unicast miss on the final destination dibit, then a hit after a 1-cycle gap
        set_hdr(48'h692C083075FC);
        send_frame(64, -1, 1);
        set_hdr(MY_MAC);
        fbuf[14] = 8'h5A; fbuf[15] = 8'hC3;
        send_frame(64, -1, 1);

        // broadcast, payload AA
        set_hdr(48'hFFFFFFFFFFFF);
        fbuf[14] = 8'hAA;
        send_frame(60, -1, 2);

        // runt frame followed by a normal 16-byte frame
        set_hdr(MY_MAC);
        send_frame(40, -1, 1);
        set_hdr(MY_MAC);
        fbuf[14] = 8'h81; fbuf[15] = 8'h7E;
        send_frame(64, -1, 1);

        // reset after 3 payload dibits with axiiv held high 20 more dibits
        set_hdr(MY_MAC);
        for (int i = 14; i < 20; i++) fbuf[i] = 8'($urandom);
        send_frame(79, 59, 1);
        set_hdr(MY_MAC);
        fbuf[14] = 8'h0F; fbuf[15] = 8'hF0;
        send_frame(64, -1, 1);

        // long frame: counter must saturate and keep forwarding
        set_hdr(MY_MAC);
        for (int i = 14; i < 54; i++) fbuf[i] = 8'($urandom);
        send_frame(216, -1, 3);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end
endmodule
